// File: rtl/hdlc_mon_pkg.sv
// Shared constants and types for the HDLC receive-path protocol monitor.
package hdlc_mon_pkg;

  localparam logic [7:0] FLAG_PATTERN = 8'b0111_1110;
  localparam int unsigned NUM_CHECKS = 4;

  // Bit index of each check within ErrCnt / ErrSticky.
  typedef enum logic [1:0] {
    ERR_FLAG_MISS     = 2'd0,
    ERR_ABORT_MISS    = 2'd1,
    ERR_IDLE          = 2'd2,
    ERR_SPURIOUS_FLAG = 2'd3
  } err_id_e;

endpackage

// File: rtl/hdlc_rx_monitor_if.sv
// Observation and report signals of the HDLC Rx monitor.
// master: the side that drives the observed Rx signals; slave: the monitor itself.
interface hdlc_rx_monitor_if #(
  parameter int unsigned CNT_W = 16
);

  logic             MonEn;
  logic             Clr;
  logic             Rx;
  logic             Rx_FlagDetect;
  logic             Rx_ValidFrame;
  logic             Rx_AbortDetect;
  logic             Rx_AbortSignal;
  logic             TxEN;
  logic             RxEN;
  logic [4*CNT_W-1:0] ErrCnt;
  logic [3:0]       ErrSticky;
  logic [1:0]       FirstErrId;
  logic             FirstErrValid;
  logic [CNT_W-1:0] ErrTotal;

  modport master (
    output MonEn, Clr, Rx, Rx_FlagDetect, Rx_ValidFrame, Rx_AbortDetect, Rx_AbortSignal,
           TxEN, RxEN,
    input  ErrCnt, ErrSticky, FirstErrId, FirstErrValid, ErrTotal
  );

  modport slave (
    input  MonEn, Clr, Rx, Rx_FlagDetect, Rx_ValidFrame, Rx_AbortDetect, Rx_AbortSignal,
           TxEN, RxEN,
    output ErrCnt, ErrSticky, FirstErrId, FirstErrValid, ErrTotal
  );

endinterface

// File: rtl/hdlc_mon_delay_pipe.sv
// Fixed-latency 1-bit expectation pipe with synchronous flush.
module hdlc_mon_delay_pipe #(
  parameter int unsigned DEPTH = 2
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Flush,
  input  logic DataIn,
  output logic DataOut
);

  logic [DEPTH-1:0] stageQ, stageD;

  // Shift one stage per cycle; flush empties every stage.
  always_comb begin
    stageD    = stageQ;
    stageD[0] = DataIn;
    for (int i = 1; i < DEPTH; i++) begin
      stageD[i] = stageQ[i-1];
    end
    if (Flush) begin
      stageD = '0;
    end
  end

  // Stage register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stageQ <= '0;
    end else begin
      stageQ <= stageD;
    end
  end

  assign DataOut = stageQ[DEPTH-1];

endmodule

// File: rtl/hdlc_rx_monitor.sv
// Run-time protocol monitor for the HDLC receive path: flag-detect timing, abort
// signalling, idle pattern and spurious flag detects, with saturating counters.
module hdlc_rx_monitor
  import hdlc_mon_pkg::*;
#(
  parameter int unsigned FLAG_LAT  = 2,
  parameter int unsigned ABORT_LAT = 1,
  parameter int unsigned IDLE_LEN  = 8,
  parameter int unsigned CNT_W     = 16
) (
  input logic              Clk,
  input logic              Rst,
  hdlc_rx_monitor_if.slave bus
);

  localparam logic [7:0]       IdleMax = 8'(IDLE_LEN);
  localparam logic [4:0]       SuppLen = 5'(FLAG_LAT + 8);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  logic [7:0] histQ, histD;
  logic       flagMatch, flagInj, flagOut;
  logic       abortInj, abortOut;
  logic [4:0] suppQ, suppD;
  logic       spurArmed;
  logic [7:0] idleQ, idleD;

  logic [NUM_CHECKS-1:0] evt;
  logic [CNT_W-1:0]      cntQ [NUM_CHECKS];
  logic [CNT_W-1:0]      cntD [NUM_CHECKS];
  logic [NUM_CHECKS-1:0] stickyQ, stickyD;
  err_id_e               firstIdQ, firstIdD;
  logic                  firstValidQ, firstValidD;
  logic [CNT_W-1:0]      totalQ, totalD;
  logic [2:0]            evtCount;
  logic [CNT_W+2:0]      totalSum;

  // Flag match includes the current Rx bit as the closing 0.
  always_comb begin
    histD     = {histQ[6:0], bus.Rx};
    flagMatch = (histD == FLAG_PATTERN);
    flagInj   = flagMatch & bus.MonEn;
    abortInj  = bus.Rx_AbortDetect & bus.Rx_ValidFrame & bus.MonEn;
  end

  hdlc_mon_delay_pipe #(
    .DEPTH (FLAG_LAT)
  ) u_flag_pipe (
    .Clk     (Clk),
    .Rst     (Rst),
    .Flush   (bus.Clr),
    .DataIn  (flagInj),
    .DataOut (flagOut)
  );

  hdlc_mon_delay_pipe #(
    .DEPTH (ABORT_LAT)
  ) u_abort_pipe (
    .Clk     (Clk),
    .Rst     (Rst),
    .Flush   (bus.Clr),
    .DataIn  (abortInj),
    .DataOut (abortOut)
  );

  // Spurious-flag warm-up and idle run-length counters, both saturating.
  always_comb begin
    suppD = (suppQ == SuppLen) ? suppQ : suppQ + 1'b1;
    if (bus.TxEN || bus.RxEN) begin
      idleD = '0;
    end else begin
      idleD = (idleQ == IdleMax) ? idleQ : idleQ + 1'b1;
    end
    if (bus.Clr) begin
      suppD = '0;
      idleD = '0;
    end
  end

  assign spurArmed = (suppQ == SuppLen);

  // Per-check error events for this cycle.
  always_comb begin
    evt                    = '0;
    evt[ERR_FLAG_MISS]     = flagOut & ~bus.Rx_FlagDetect;
    evt[ERR_ABORT_MISS]    = abortOut & ~bus.Rx_AbortSignal;
    evt[ERR_IDLE]          = (idleQ == IdleMax) & bus.MonEn & ~bus.Rx;
    evt[ERR_SPURIOUS_FLAG] = bus.Rx_FlagDetect & ~flagOut & spurArmed & bus.MonEn;
  end

  // Counter, sticky, total and first-error next state; Clr overrides events.
  always_comb begin
    evtCount = '0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      evtCount = evtCount + {2'b00, evt[i]};
    end
    totalSum = {3'b000, totalQ} + {{CNT_W{1'b0}}, evtCount};
    totalD   = (totalSum > {3'b000, CntMax}) ? CntMax : totalSum[CNT_W-1:0];
    for (int i = 0; i < NUM_CHECKS; i++) begin
      cntD[i] = cntQ[i];
      if (evt[i] && (cntQ[i] != CntMax)) begin
        cntD[i] = cntQ[i] + 1'b1;
      end
    end
    stickyD     = stickyQ | evt;
    firstIdD    = firstIdQ;
    firstValidD = firstValidQ;
    if (!firstValidQ && (|evt)) begin
      firstValidD = 1'b1;
      // Scan downwards so the lowest index wins.
      for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
        if (evt[i]) begin
          firstIdD = err_id_e'(2'(i));
        end
      end
    end
    if (bus.Clr) begin
      for (int i = 0; i < NUM_CHECKS; i++) begin
        cntD[i] = '0;
      end
      stickyD     = '0;
      totalD      = '0;
      firstIdD    = ERR_FLAG_MISS;
      firstValidD = 1'b0;
    end
  end

  // History, warm-up and idle state.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      histQ <= '0;
      suppQ <= '0;
      idleQ <= '0;
    end else begin
      histQ <= bus.Clr ? 8'h00 : histD;
      suppQ <= suppD;
      idleQ <= idleD;
    end
  end

  // Error reporting state.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < NUM_CHECKS; i++) begin
        cntQ[i] <= '0;
      end
      stickyQ     <= '0;
      totalQ      <= '0;
      firstIdQ    <= ERR_FLAG_MISS;
      firstValidQ <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CHECKS; i++) begin
        cntQ[i] <= cntD[i];
      end
      stickyQ     <= stickyD;
      totalQ      <= totalD;
      firstIdQ    <= firstIdD;
      firstValidQ <= firstValidD;
    end
  end

  // Pack counters onto the report bus.
  always_comb begin
    bus.ErrCnt = '0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      bus.ErrCnt[i*CNT_W +: CNT_W] = cntQ[i];
    end
  end

  assign bus.ErrSticky     = stickyQ;
  assign bus.FirstErrId    = firstIdQ;
  assign bus.FirstErrValid = firstValidQ;
  assign bus.ErrTotal      = totalQ;

endmodule

// File: tb/tb_hdlc_rx_monitor.sv
// Directed bench for hdlc_rx_monitor (CNT_W=4 so saturation is reachable).
module tb_hdlc_rx_monitor;

  localparam int unsigned CNT_W = 4;

  logic Clk = 1'b0;
  logic Rst;
  int   nChecks;
  int   nErrors;

  hdlc_rx_monitor_if #(.CNT_W(CNT_W)) bus ();

  hdlc_rx_monitor #(
    .FLAG_LAT  (2),
    .ABORT_LAT (1),
    .IDLE_LEN  (8),
    .CNT_W     (CNT_W)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cntOf(input int idx);
    return 32'(bus.ErrCnt[idx*CNT_W +: CNT_W]);
  endfunction

  task automatic chkAllClear(input string tag);
    chk({tag, "_cnt"}, 32'(bus.ErrCnt), 32'h0);
    chk({tag, "_sticky"}, 32'(bus.ErrSticky), 32'h0);
    chk({tag, "_id"}, 32'(bus.FirstErrId), 32'h0);
    chk({tag, "_valid"}, 32'(bus.FirstErrValid), 32'h0);
    chk({tag, "_total"}, 32'(bus.ErrTotal), 32'h0);
  endtask

  task automatic doClr();
    bus.Clr = 1'b1;
    tick();
    bus.Clr = 1'b0;
  endtask

  // Opening 0, six 1s, closing 0; returns right after the closing-0 cycle.
  task automatic sendFlag();
    bus.Rx = 1'b0;
    tick();
    repeat (6) begin
      bus.Rx = 1'b1;
      tick();
    end
    bus.Rx = 1'b0;
    tick();
    bus.Rx = 1'b1;
  endtask

  initial begin
    nChecks            = 0;
    nErrors            = 0;
    bus.MonEn          = 1'b1;
    bus.Clr            = 1'b0;
    bus.Rx             = 1'b1;
    bus.Rx_FlagDetect  = 1'b0;
    bus.Rx_ValidFrame  = 1'b0;
    bus.Rx_AbortDetect = 1'b0;
    bus.Rx_AbortSignal = 1'b0;
    bus.TxEN           = 1'b0;
    bus.RxEN           = 1'b1;
    Rst                = 1'b1;
    repeat (2) tick();
    chkAllClear("reset");
    Rst = 1'b0;
    repeat (12) tick();

    // Flag answered two cycles after the closing 0.
    sendFlag();
    tick();
    bus.Rx_FlagDetect = 1'b1;
    tick();
    bus.Rx_FlagDetect = 1'b0;
    chk("flag_ok_cnt", 32'(bus.ErrCnt), 32'h0);
    tick();
    chk("flag_ok_sticky", 32'(bus.ErrSticky), 32'h0);
    chk("flag_ok_total", 32'(bus.ErrTotal), 32'h0);

    // Flag never answered.
    sendFlag();
    tick();
    tick();
    chk("flag_miss_cnt0", cntOf(0), 32'd1);
    chk("flag_miss_sticky", 32'(bus.ErrSticky), 32'h1);
    chk("flag_miss_id", 32'(bus.FirstErrId), 32'h0);
    chk("flag_miss_valid", 32'(bus.FirstErrValid), 32'h1);
    chk("flag_miss_total", 32'(bus.ErrTotal), 32'd1);
    doClr();
    chkAllClear("clr1");

    // Abort not signalled, then signalled, then detect outside a valid frame.
    bus.Rx_AbortDetect = 1'b1;
    bus.Rx_ValidFrame  = 1'b1;
    tick();
    bus.Rx_AbortDetect = 1'b0;
    bus.Rx_ValidFrame  = 1'b0;
    chk("abort_early_cnt1", cntOf(1), 32'd0);
    tick();
    chk("abort_miss_cnt1", cntOf(1), 32'd1);
    bus.Rx_AbortDetect = 1'b1;
    bus.Rx_ValidFrame  = 1'b1;
    tick();
    bus.Rx_AbortDetect = 1'b0;
    bus.Rx_ValidFrame  = 1'b0;
    bus.Rx_AbortSignal = 1'b1;
    tick();
    bus.Rx_AbortSignal = 1'b0;
    bus.Rx_AbortDetect = 1'b1;
    tick();
    bus.Rx_AbortDetect = 1'b0;
    repeat (2) tick();
    chk("abort_ok_cnt1", cntOf(1), 32'd1);
    chk("abort_id", 32'(bus.FirstErrId), 32'h1);
    chk("abort_total", 32'(bus.ErrTotal), 32'd1);
    doClr();

    // Idle: 8 quiet cycles arm the check, then 3 cycles of Rx=0.
    bus.RxEN = 1'b0;
    repeat (8) tick();
    chk("idle_armed_cnt2", cntOf(2), 32'd0);
    bus.Rx = 1'b0;
    repeat (3) tick();
    bus.Rx   = 1'b1;
    bus.RxEN = 1'b1;
    chk("idle_err_cnt2", cntOf(2), 32'd3);
    tick();
    chk("idle_total", 32'(bus.ErrTotal), 32'd3);
    chk("idle_id", 32'(bus.FirstErrId), 32'h2);
    doClr();

    // RxEN rises before the counter reaches 8.
    bus.RxEN = 1'b0;
    repeat (7) tick();
    bus.RxEN = 1'b1;
    tick();
    bus.RxEN = 1'b0;
    bus.Rx   = 1'b0;
    repeat (3) tick();
    bus.Rx   = 1'b1;
    bus.RxEN = 1'b1;
    tick();
    chk("idle_short_cnt2", cntOf(2), 32'd0);

    // Armed idle with the monitor disabled.
    bus.RxEN = 1'b0;
    repeat (8) tick();
    bus.MonEn = 1'b0;
    bus.Rx    = 1'b0;
    repeat (2) tick();
    bus.Rx    = 1'b1;
    bus.RxEN  = 1'b1;
    bus.MonEn = 1'b1;
    tick();
    chk("idle_monen_cnt2", cntOf(2), 32'd0);

    // Spurious detect inside the post-Clr warm-up is ignored.
    doClr();
    tick();
    bus.Rx_FlagDetect = 1'b1;
    tick();
    bus.Rx_FlagDetect = 1'b0;
    tick();
    chk("spur_warmup_cnt3", cntOf(3), 32'd0);
    repeat (12) tick();

    // Flag miss followed by a spurious detect.
    sendFlag();
    tick();
    tick();
    bus.Rx_FlagDetect = 1'b1;
    tick();
    bus.Rx_FlagDetect = 1'b0;
    chk("mix_cnt0", cntOf(0), 32'd1);
    chk("mix_cnt3", cntOf(3), 32'd1);
    chk("mix_total", 32'(bus.ErrTotal), 32'd2);
    chk("mix_id", 32'(bus.FirstErrId), 32'h0);
    chk("mix_sticky", 32'(bus.ErrSticky), 32'h9);
    doClr();
    chkAllClear("clr2");

    // Abort miss and spurious flag in the same cycle: lower index wins.
    repeat (12) tick();
    bus.Rx_AbortDetect = 1'b1;
    bus.Rx_ValidFrame  = 1'b1;
    tick();
    bus.Rx_AbortDetect = 1'b0;
    bus.Rx_ValidFrame  = 1'b0;
    bus.Rx_FlagDetect  = 1'b1;
    tick();
    bus.Rx_FlagDetect  = 1'b0;
    chk("simul_sticky", 32'(bus.ErrSticky), 32'ha);
    chk("simul_id", 32'(bus.FirstErrId), 32'h1);
    chk("simul_total", 32'(bus.ErrTotal), 32'd2);
    doClr();

    // 20 back-to-back flags sharing zeros, none answered.
    bus.Rx = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      repeat (6) begin
        bus.Rx = 1'b1;
        tick();
      end
      bus.Rx = 1'b0;
      tick();
      if (i == 2) chk("b2b_cnt0", cntOf(0), 32'd2);
    end
    bus.Rx = 1'b1;
    repeat (2) tick();
    chk("sat_cnt0", cntOf(0), 32'd15);
    chk("sat_total", 32'(bus.ErrTotal), 32'd15);
    chk("sat_sticky", 32'(bus.ErrSticky), 32'h1);

    // Reset with a flag expectation in flight.
    sendFlag();
    Rst = 1'b1;
    #1;
    chk("rst_async_total", 32'(bus.ErrTotal), 32'h0);
    tick();
    Rst = 1'b0;
    repeat (4) tick();
    chkAllClear("rst_inflight");

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/hdlc_rx_monitor.md
Name: hdlc_rx_monitor

Overview:
Synthesizable, parametrised run-time protocol monitor for the HDLC receive path. It sits beside the Rx module and watches the serial Rx line plus Rx status outputs. It checks flag-detect timing, abort signalling, idle pattern and spurious flag detects, and reports per-check saturating error counters, sticky flags and the first-error identity. It is usable in the testbench and in emulation, where concurrent assertions are unavailable.

Parameters:
FLAG_LAT, 2, cycles from the last flag bit on Rx to the expected Rx_FlagDetect (1..7)
ABORT_LAT, 1, cycles from Rx_AbortDetect&&Rx_ValidFrame to the expected Rx_AbortSignal (1..7)
IDLE_LEN, 8, consecutive cycles both enables must be low before the idle check arms (1..255)
CNT_W, 16, width of each error counter

Ports:
Clk  input  1  system clock
Rst  input  1  asynchronous reset, active-high
MonEn  input  1  monitor enable; when 0 no new expectations or errors are recorded
Clr  input  1  synchronous clear of counters, sticky flags and first-error capture
Rx  input  1  serial receive line
Rx_FlagDetect  input  1  DUT flag-detect strobe
Rx_ValidFrame  input  1  DUT valid-frame status
Rx_AbortDetect  input  1  DUT abort-detect strobe
Rx_AbortSignal  input  1  DUT abort-signal output
TxEN  input  1  transmit enable
RxEN  input  1  receive enable
ErrCnt  output  4*CNT_W  packed per-check counters: [0] flag-miss, [1] abort-miss, [2] idle, [3] spurious-flag
ErrSticky  output  4  sticky per-check error bits, same index order as ErrCnt
FirstErrId  output  2  index of the first error since reset/Clr
FirstErrValid  output  1  FirstErrId is valid
ErrTotal  output  CNT_W  saturating sum of all error events

Behaviour:
- Reset (Rst=1, async): all counters, ErrSticky, FirstErrId, FirstErrValid, ErrTotal, the history shift register, the pending pipes and the idle counter go to 0.
- Rx history: an 8-bit shift register captures Rx every cycle. A flag match occurs when the history equals 0111_1110, i.e. the current Rx is the closing 0.
- Flag pipe: a FLAG_LAT-deep shift of expectation bits. A match with MonEn=1 injects 1.
  - When the bit exits the pipe and Rx_FlagDetect=0 that cycle, a flag-miss error fires.
  - Back-to-back flags sharing a 0 (0111_1110_111_1110) produce two independent expectations.
- Spurious flag: Rx_FlagDetect=1 while the flag pipe output is 0 fires a spurious-flag error. Checking is suppressed for the first FLAG_LAT+8 cycles after reset/Clr.
- Abort pipe: an ABORT_LAT-deep pipe. Rx_AbortDetect&&Rx_ValidFrame&&MonEn injects 1; output 1 with Rx_AbortSignal=0 fires an abort-miss error.
- Idle check:
  - The idle counter (8 bits, saturating at IDLE_LEN) increments while TxEN=0 and RxEN=0, and clears when either is 1.
  - When the counter equals IDLE_LEN, MonEn=1 and Rx=0, an idle error fires once per cycle.
- Error event: the counter increments by 1 and saturates at 2^CNT_W-1 with no wrap. The matching ErrSticky bit sets. ErrTotal increments by the number of simultaneous events (0..4), saturating.
- First error: capture happens on the first cycle any event fires while FirstErrValid=0. If several fire together, the lowest index wins. FirstErrValid is held until Rst or Clr.
- Clr=1: outputs return to reset values on the next edge. Pipes and history are also flushed. An event coinciding with Clr is discarded (Clr wins).
- MonEn=0: no injections and no idle errors. Expectations already in flight still mature and are checked.
- Outputs are registered; an error is visible one cycle after the checking cycle.
- Rst asserted mid-frame drops all in-flight expectations; no error is reported for them.

Decomposition:
- Package hdlc_mon_pkg holds:
  - FLAG_PATTERN = 8'b0111_1110
  - the error-index enum err_id_e {ERR_FLAG_MISS, ERR_ABORT_MISS, ERR_IDLE, ERR_SPURIOUS_FLAG}
  - NUM_CHECKS = 4
- One sub-module, hdlc_mon_delay_pipe (parameter DEPTH; in/out bit, flush, async reset), instanced for the flag and abort pipes.
- Counters and first-error logic live in the top module.

Test Plan:
- Drive Rx=1,0,1,1,1,1,1,1,0 with DUT model pulsing Rx_FlagDetect 2 cycles after the final 0 -> ErrCnt all 0, ErrSticky=0000.
- Same flag with Rx_FlagDetect never asserted -> ErrCnt[0]=1, ErrSticky=0001, FirstErrId=0, FirstErrValid=1, ErrTotal=1.
- Rx_AbortDetect=1 and Rx_ValidFrame=1 for one cycle, Rx_AbortSignal held 0 -> ErrCnt[1]=1 one cycle after the check. A second run with Rx_AbortSignal=1 next cycle -> no error.
- TxEN=RxEN=0 for 8 cycles, then Rx=0 for 3 cycles -> ErrCnt[2]=3. Raising RxEN before cycle 8 -> 0 errors.
- Rx_FlagDetect pulsed with no flag on Rx plus a simultaneous flag-miss -> ErrCnt[0]=1, ErrCnt[3]=1, ErrTotal=2, FirstErrId=0. Then Clr=1 -> all outputs 0.
- CNT_W=4: force 20 flag misses -> ErrCnt[0]=15 (saturated). Rst asserted with a flag expectation in flight -> no error after release.
